// File: rtl/useq_sequencer.sv
// useq_sequencer: writable-microcode sequencer with run-time loaded store and two dispatch tables
//
// Parameters: STATE_W (state/address width), IN_W (condition input width),
//             CTRL_W (control field width), RESET_STATE (state after reset)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   en                        advance enable, 0 holds state
//   in                        condition / dispatch input
//   mc_we, mc_addr, mc_wdata  microcode write port, word = {ctrl, target, bc}
//   dt_we, dt_sel, dt_addr, dt_wdata  dispatch write port, dt_sel 0/1 = table 1/2
//   state                     registered current state
//   ctrl                      control field of mem[state]
//   waiting                   current op is WAIT and in == 0
//   err                       one-cycle pulse on RET with empty return register
// Optional feature: define USEQ_CALL_STACK_EN for a one-entry CALL/RET return register;
// without it CALL acts as JUMP, RET goes to RESET_STATE and err is tied low.
module useq_sequencer #(
    parameter int STATE_W     = 4,
    parameter int IN_W        = 2,
    parameter int CTRL_W      = 8,
    parameter int RESET_STATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [IN_W-1:0]           in,
    input  logic                      mc_we,
    input  logic [STATE_W-1:0]        mc_addr,
    input  logic [3+STATE_W+CTRL_W-1:0] mc_wdata,
    input  logic                      dt_we,
    input  logic                      dt_sel,
    input  logic [IN_W-1:0]           dt_addr,
    input  logic [STATE_W-1:0]        dt_wdata,
    output logic [STATE_W-1:0]        state,
    output logic [CTRL_W-1:0]         ctrl,
    output logic                      waiting,
    output logic                      err
);
    localparam int W = 3 + STATE_W + CTRL_W;
    localparam logic [2:0] OP_SEQ   = 3'd0;
    localparam logic [2:0] OP_DISP1 = 3'd1;
    localparam logic [2:0] OP_DISP2 = 3'd2;
    localparam logic [2:0] OP_JUMP  = 3'd3;
    localparam logic [2:0] OP_BR    = 3'd4;
    localparam logic [2:0] OP_WAIT  = 3'd5;
    localparam logic [2:0] OP_CALL  = 3'd6;
    localparam logic [2:0] OP_RET   = 3'd7;
    localparam logic [STATE_W-1:0] RST_ST = STATE_W'(RESET_STATE);

    logic [W-1:0]       mem [2**STATE_W];
    logic [STATE_W-1:0] dt1 [2**IN_W];
    logic [STATE_W-1:0] dt2 [2**IN_W];
    logic [W-1:0]       w;
    logic [2:0]         bc;
    logic [STATE_W-1:0] target;
    logic [STATE_W-1:0] inc;
    logic [STATE_W-1:0] nxt;

    // RAMs are deliberately outside reset so contents survive rst
    always_ff @(posedge clk) begin
        if (mc_we) mem[mc_addr] <= mc_wdata;
        if (dt_we && !dt_sel) dt1[dt_addr] <= dt_wdata;
        if (dt_we && dt_sel) dt2[dt_addr] <= dt_wdata;
    end

    assign w      = mem[state];
    assign bc     = w[2:0];
    assign target = w[3 +: STATE_W];
    assign inc    = state + STATE_W'(1);

`ifdef USEQ_CALL_STACK_EN
    logic [STATE_W-1:0] ret;
    logic               rv;
    logic               err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rv    <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= en && bc == OP_RET && !rv;
            if (en && bc == OP_CALL) begin
                ret <= inc;
                rv  <= 1'b1;
            end else if (en && bc == OP_RET) begin
                rv <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RST_ST;
        else if (en) state <= nxt;
    end

    always_comb begin
        nxt = inc;
        case (bc)
            OP_SEQ:           nxt = inc;
            OP_DISP1:         nxt = dt1[in];
            OP_DISP2:         nxt = dt2[in];
            OP_JUMP, OP_CALL: nxt = target;
            OP_BR:            nxt = in[0] ? target : inc;
            OP_WAIT:          nxt = (in == '0) ? state : inc;
`ifdef USEQ_CALL_STACK_EN
            OP_RET:           nxt = rv ? ret : RST_ST;
`else
            OP_RET:           nxt = RST_ST;
`endif
            default:          nxt = inc;
        endcase
    end

    always_comb begin
        ctrl    = w[3+STATE_W +: CTRL_W];
        waiting = bc == OP_WAIT && in == '0;
    end
endmodule

// File: doc/useq_sequencer.md
Name: useq_sequencer

Overview:
- Parametrised, writable-microcode sequencer. It is the next generation of the team's fixed 4-bit microcode-ROM FSM.
- State width, input width and control-word width are parameters.
- Microcode store and two dispatch tables are RAMs loaded at run time through a write port.
- Each microword carries a branch opcode, a jump target and a control field that drives the datapath.

Parameters:
- STATE_W, 4: state/address width. The store has 2**STATE_W microwords.
- IN_W, 2: width of the condition/dispatch input. Each dispatch table has 2**IN_W entries.
- CTRL_W, 8: width of the control field output per microword.
- RESET_STATE, 0: state loaded on reset.

Ports:
- clk  in  1  clock; all updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 holds the state.
- in  in  IN_W  condition/dispatch input.
- mc_we  in  1  microcode write strobe.
- mc_addr  in  STATE_W  microcode write address.
- mc_wdata  in  3+STATE_W+CTRL_W  microword, packed as {ctrl, target, bc}.
- dt_we  in  1  dispatch-table write strobe.
- dt_sel  in  1  table select: 0 = table 1, 1 = table 2.
- dt_addr  in  IN_W  dispatch entry address.
- dt_wdata  in  STATE_W  dispatch entry data.
- state  out  STATE_W  current state, registered.
- ctrl  out  CTRL_W  ctrl field of mem[state], combinational.
- waiting  out  1  high when the current op is WAIT and in==0.
- err  out  1  one-cycle pulse on RET with an empty stack; always 0 without the macro.

Behaviour:
- Reset (rst=1 at posedge): state<=RESET_STATE. Stack valid flag <=0. err<=0.
- Microcode and dispatch RAM contents are not reset and survive rst.
- Current word w = mem[state], with fields bc = w[2:0], target, ctrl. Next state nxt is decoded from bc:
  - 000 SEQ: state+1, mod 2**STATE_W (wraps to 0 at the top address).
  - 001 DISP1: dt1[in].
  - 010 DISP2: dt2[in].
  - 011 JUMP: target.
  - 100 BR: in[0] ? target : state+1.
  - 101 WAIT: (in==0) ? state : state+1.
  - 110 CALL: see Optional Feature.
  - 111 RET: see Optional Feature.
- Update at posedge: if rst, reset. Else if en, state<=nxt. Else state holds.
- When en=0: no stack change, no err pulse; ctrl still reflects mem[state].
- Latency: one clock from in/opcode to the state change. ctrl and waiting follow state combinationally.
- RAM writes take effect at the posedge and are independent of en and rst.
  - A write to mem[state] in the same cycle does not affect that cycle's nxt; the old word is used.
  - The new ctrl is visible from the next cycle.
  - Dispatch writes behave the same way.
- mc_we and dt_we may be asserted together; both writes complete.
- rst together with en: rst wins. Reset mid-sequence abandons the sequence immediately.

Optional Feature:
- Macro USEQ_CALL_STACK_EN.
- Defined: one-entry return register ret plus valid flag rv.
  - CALL: nxt=target; ret<=state+1 (wrapped); rv<=1. A CALL with rv already set overwrites ret.
  - RET with rv=1: nxt=ret; rv<=0.
  - RET with rv=0: nxt=RESET_STATE; err pulses high for 1 cycle.
- Not defined:
  - CALL behaves exactly as JUMP.
  - RET gives nxt=RESET_STATE.
  - err is tied to 0.
  - No ret/rv storage is built.

Test Plan:
1. Defaults. Load mem[0..3] as SEQ, mem[3]=JUMP target 0; en=1; release rst -> state sequence 0,1,2,3,0,1; ctrl matches each loaded ctrl field every cycle.
2. Load dt1={4,7,9,12}; mem[0]=DISP1. For in=0..3 (reset between runs) -> state 4,7,9,12 one cycle after rst release.
3. mem[2]=WAIT; hold in=0 for 5 cycles -> state stays 2, waiting=1. Set in=1 -> state 3 next cycle, waiting=0. With en=0 and in=1 -> state stays 2.
4. mem[15]=SEQ -> state wraps 15 -> 0. mem[5]=BR target 10: in=2'b01 -> 10; in=2'b10 -> 6.
5. Macro on: mem[1]=CALL 8, mem[8]=RET -> states 1,8,2. A second RET with no CALL -> state 0 and err=1 for exactly 1 cycle. Macro off: same program -> 1,8,0 with err=0.
6. Assert rst during a WAIT loop -> state=0 next cycle. Write mem[state] while en=1 -> the transition uses the old word; ctrl shows the new value the following cycle.
